// File: rtl/bp_pkg.sv
// Shared types and constants for the bimodal branch predictor / BTB.
package bp_pkg;

  // Widest tag any legal table depth needs; narrower tags are zero-extended.
  localparam int TAG_MAX_W = 30;

  localparam logic [1:0]  CTR_SNT = 2'd0;
  localparam logic [1:0]  CTR_WNT = 2'd1;
  localparam logic [1:0]  CTR_WT  = 2'd2;
  localparam logic [1:0]  CTR_ST  = 2'd3;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
    logic                 is_jump;
  } bp_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == CTR_ST)  ? ctr : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? ctr : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor storage: registered fetch read, combinational training lookup,
// one write port and a single-entry invalidate port for the init sweep.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_entry_t        rd_data,
  input  logic [IDX_W-1:0] look_idx,
  output bp_entry_t        look_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  bp_entry_t        wr_data,
  input  logic             inv_en,
  input  logic [IDX_W-1:0] inv_idx
);

  bp_entry_t mem [ENTRIES];

  // NOTE: the array has no reset; the FSM sweep clears every valid bit before
  // any lookup is trusted, so the storage maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (inv_en)     mem[inv_idx].valid <= 1'b0;
    else if (wr_en) mem[wr_idx]        <= wr_data;
  end

  // Non-blocking read here gives read-before-write against a same-edge update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
  end

  assign look_data = mem[look_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with integrated BTB: init/flush FSM, prediction
// from a registered table read, training and saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_tbl,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_is_jump,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        busy,
  output logic [31:0] upd_count,
  output logic [31:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_state_e        state, state_d;
  logic [IDX_W-1:0] init_idx, init_idx_d;
  logic             inv_en;

  logic             fetch_en;
  logic             pred_valid_q;
  logic             have_pred_q;
  logic [31:0]      pc_q;
  logic [TAG_MAX_W-1:0] pc_q_tag, upd_tag;

  bp_entry_t        rd_data, look_data, wr_data;
  logic             wr_en, upd_accept, upd_hit, mispred;

  logic             unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0], pc_q[1:0]};

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_d;
      init_idx <= init_idx_d;
    end
  end

  always_comb begin
    // NOTE: defaults first on every path, so no latch is inferred.
    state_d    = state;
    init_idx_d = init_idx;
    inv_en     = 1'b0;
    if (flush_tbl) begin
      state_d    = INIT;
      init_idx_d = '0;
    end else if (state == INIT) begin
      inv_en     = 1'b1;
      init_idx_d = init_idx + 1'b1;
      if (init_idx == IDX_W'(ENTRIES - 1)) state_d = READY;
    end
  end

  assign busy = (state == INIT);

  // ---------------- prediction ----------------
  assign fetch_en = (state == READY) && fetch_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      have_pred_q  <= 1'b0;
      pc_q         <= '0;
    end else begin
      pred_valid_q <= fetch_en;
      if (fetch_en) begin
        have_pred_q <= 1'b1;
        pc_q        <= fetch_pc;
      end
    end
  end

  assign pc_q_tag    = TAG_MAX_W'(pc_q[31:2] >> IDX_W);
  assign pred_valid  = pred_valid_q && (state == READY);
  assign pred_hit    = have_pred_q && rd_data.valid && (rd_data.tag == pc_q_tag);
  assign pred_taken  = pred_hit && (rd_data.is_jump || rd_data.ctr[1]);
  assign pred_target = !have_pred_q ? 32'd0 :
                       pred_taken   ? rd_data.target : pc_q + 32'd4;

  // ---------------- training ----------------
  assign upd_tag    = TAG_MAX_W'(upd_pc[31:2] >> IDX_W);
  assign upd_accept = (state == READY) && upd_valid && !flush_tbl;
  assign upd_hit    = look_data.valid && (look_data.tag == upd_tag);
  assign mispred    = (upd_pred_taken != upd_taken) ||
                      (upd_taken && (upd_pred_target != upd_target));

  always_comb begin
    wr_en   = 1'b0;
    wr_data = look_data;
    if (upd_accept) begin
      if (upd_hit) begin
        wr_en           = 1'b1;
        wr_data.ctr     = ctr_next(look_data.ctr, upd_taken);
        wr_data.is_jump = upd_is_jump;
        if (upd_taken) wr_data.target = upd_target;
      end else if (upd_taken) begin
        wr_en           = 1'b1;
        wr_data.valid   = 1'b1;
        wr_data.tag     = upd_tag;
        wr_data.target  = upd_target;
        wr_data.ctr     = CTR_WT;
        wr_data.is_jump = upd_is_jump;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_count     <= '0;
      mispred_count <= '0;
    end else if (upd_accept) begin
      if (upd_count != CNT_MAX)                mispred_count <= mispred_count;
      if (upd_count != CNT_MAX)                upd_count     <= upd_count + 32'd1;
      if (mispred && mispred_count != CNT_MAX) mispred_count <= mispred_count + 32'd1;
    end
  end

  bp_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (fetch_en),
    .rd_idx    (fetch_pc[IDX_W+1:2]),
    .rd_data   (rd_data),
    .look_idx  (upd_pc[IDX_W+1:2]),
    .look_data (look_data),
    .wr_en     (wr_en),
    .wr_idx    (upd_pc[IDX_W+1:2]),
    .wr_data   (wr_data),
    .inv_en    (inv_en),
    .inv_idx   (init_idx)
  );

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch predictor with an integrated branch target buffer, sitting in the fetch stage. It supplies a taken/not-taken guess and a target for each fetch PC. The branch unit in execute is the other end of the loop: its resolved `take_branch` outcome, the computed target and the prediction carried down the pipe come back here to train 2-bit saturating counters. The block also keeps update and misprediction statistics.

## Interface

Parameters:
- `ENTRIES`, 64: table depth. Must be a power of two, ≥ 4.
- `IDX_W`, $clog2(ENTRIES): index width (derived, not overridable).
- `TAG_W`, 30 − IDX_W: tag width (derived).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush_tbl` in 1: request to invalidate the whole table.
- `fetch_valid` in 1: a fetch PC is presented.
- `fetch_pc` in 32: fetch address, word aligned.
- `pred_valid` out 1: prediction outputs valid this cycle.
- `pred_hit` out 1: the BTB entry matched.
- `pred_taken` out 1: predicted taken.
- `pred_target` out 32: predicted next PC.
- `upd_valid` in 1: a resolved branch or jump from execute.
- `upd_pc` in 32: PC of the resolved instruction.
- `upd_taken` in 1: resolved outcome (the branch unit's `take_branch`).
- `upd_is_jump` in 1: the instruction is an unconditional jump.
- `upd_target` in 32: resolved target.
- `upd_pred_taken` in 1: prediction originally issued for this instruction.
- `upd_pred_target` in 32: target originally issued for this instruction.
- `busy` out 1: table initialisation in progress.
- `upd_count` out 32: accepted updates, saturating.
- `mispred_count` out 32: mispredictions, saturating.

## Operation

**Address fields**
- Index = `pc[IDX_W+1:2]`.
- Tag = `pc[31:IDX_W+2]`.

**Entry contents:** `valid`, `tag`, `target[31:0]`, `ctr[1:0]`, `is_jump`.

**FSM states: INIT, READY.**

INIT:
- Clears `valid` at `init_idx`, one entry per cycle, starting from 0.
- Moves to READY after clearing entry ENTRIES−1.
- `busy` = 1 while in INIT.
- `pred_valid` is forced to 0.
- Updates are dropped and counters are not touched.

READY:
- `flush_tbl` = 1 moves to INIT with `init_idx` = 0 at the next edge.
- `flush_tbl` = 1 while already in INIT restarts the sweep at 0.

**Prediction (READY)**
- hit = entry valid and tag match.
- `pred_taken` = hit & (`is_jump` | `ctr[1]`).
- `pred_target` = stored target when `pred_taken`, otherwise `fetch_pc` + 4 (mod 2^32).

**Update (READY and `upd_valid`)**
- On a hit:
  - `ctr` is incremented if taken, decremented if not taken, saturating at 3 and 0.
  - `is_jump` is set to `upd_is_jump`.
  - `target` is overwritten only when `upd_taken` = 1.
- On a miss with `upd_taken` = 1: allocate/replace the entry with `valid` = 1, the new tag and target, `ctr` = 2'b10, and `is_jump`.
- On a miss with `upd_taken` = 0: no table write.

**Misprediction**
- Defined as (`upd_pred_taken` ≠ `upd_taken`) | (`upd_taken` & `upd_pred_target` ≠ `upd_target`).
- `upd_count` increments on every accepted update.
- `mispred_count` increments on every accepted misprediction.
- Both counters hold at 32'hFFFF_FFFF.
- Both counters are cleared only by `rst_n`, never by `flush_tbl`.

## Timing

**Reset values**
- `pred_valid`, `pred_hit`, `pred_taken` = 0.
- `pred_target` = 0.
- `busy` = 1.
- Both counters = 0.
- State = INIT, `init_idx` = 0.

**Initialisation timing:** after `rst_n` deasserts, `busy` stays high for exactly ENTRIES cycles.

**Prediction latency**
- One cycle: the outputs are registered from the `fetch_valid`/`fetch_pc` sampled at edge N and appear after edge N.
- `pred_valid` equals `fetch_valid` delayed one cycle (READY only).
- When `fetch_valid` = 0, `pred_valid` = 0 and the other prediction outputs hold their last value.

**Update timing:** the table write and counter increment take effect at the edge where `upd_valid` is sampled.

**Same-cycle read and write to one index:** the prediction uses the pre-write contents (read-before-write). No bypass.

**Edge cases**
- `flush_tbl` together with `upd_valid` in READY: the flush wins, the update is dropped and the counters are unchanged.
- `rst_n` asserted mid-sweep or mid-operation: every register returns to its reset value immediately, with no clock needed.

## Structure

**Package `bp_pkg`:**
- `bp_entry_t` struct.
- `bp_state_e` enum {INIT, READY}.
- Counter constants `CTR_SNT`=0, `CTR_WNT`=1, `CTR_WT`=2, `CTR_ST`=3.
- `CNT_MAX` = 32'hFFFF_FFFF.

**Sub-module `bp_table`:**
- ENTRIES-deep storage.
- One registered read port.
- One write port, plus a single-entry invalidate port driven by the FSM.

**Top level:** FSM, hit/predict logic, counter update and statistics counters.

## Test plan

1. Reset, hold `fetch_valid` = 1 → `busy` = 1 for 64 cycles, `pred_valid` = 0 throughout, then `pred_valid` = 1, `pred_hit` = 0, `pred_target` = PC+4.
2. Update pc = 0x100, taken, target = 0x200, `upd_pred_taken` = 0 → fetch 0x100 next yields `pred_hit` = 1, `pred_taken` = 1, `pred_target` = 0x200; `upd_count` = 1, `mispred_count` = 1.
3. Counter walk at 0x100: three not-taken updates → `pred_taken` goes 1, 0, 0 (`ctr` 2→1→0, saturates at 0); four taken updates → `ctr` saturates at 3.
4. Alias: 0x100 entry taken, then taken update at 0x100 + 4·64 → 0x100 misses, and the new PC hits with its own target.
5. Jump with `upd_is_jump` = 1 followed by three not-taken updates to the same PC → still predicted taken. Not-taken update on an empty index → no allocation, `pred_hit` stays 0.
6. Same-cycle fetch and update to one index → the old prediction appears first, the new one on the next fetch. `flush_tbl` with `upd_valid` → update ignored, `busy` high for 64 cycles, `upd_count` unchanged.
